// File: rtl/sm_reg_dump.sv
// Debug register dumper: walks CPU debug addresses REG_FIRST..REG_LAST and streams each
// 32-bit value MSB-byte first over an 8N1 UART line. Define SM_REG_DUMP_HEADER_EN to prefix each register with {3'b101, addr}.
module sm_reg_dump #(
    parameter int BAUD_DIV  = 434,
    parameter int REG_FIRST = 0,
    parameter int REG_LAST  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
    localparam logic [4:0]    ADDR_FIRST = 5'(REG_FIRST);
    localparam logic [4:0]    ADDR_LAST  = 5'(REG_LAST);
`ifdef SM_REG_DUMP_HEADER_EN
    localparam logic [2:0]    BYTE_TOP   = 3'd4;
`else
    localparam logic [2:0]    BYTE_TOP   = 3'd3;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LATCH,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        NEXT,
        DONE
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [BW-1:0]  baud_cnt;
    logic [2:0]     bit_cnt;
    logic [2:0]     byte_idx;
    logic [31:0]    shreg;
    logic [4:0]     reg_addr;
    logic [7:0]     tx_byte;
    logic           baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign regAddr  = reg_addr;

    // byte_idx counts down 3..0 through the data bytes; index 4 is the optional header
    always_comb begin
        tx_byte = 8'h00;
        case (byte_idx)
            3'd3:    tx_byte = shreg[31:24];
            3'd2:    tx_byte = shreg[23:16];
            3'd1:    tx_byte = shreg[15:8];
            3'd0:    tx_byte = shreg[7:0];
            default: tx_byte = {3'b101, reg_addr};
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = ADDR;
            ADDR:      state_d = LATCH;
            LATCH:     state_d = START_BIT;
            START_BIT: if (baud_end) state_d = DATA_BITS;
            DATA_BITS: if (baud_end && bit_cnt == 3'd7) state_d = STOP_BIT;
            STOP_BIT: begin
                if (baud_end) begin
                    if (byte_idx != 3'd0)
                        state_d = START_BIT;
                    else if (reg_addr == ADDR_LAST)
                        state_d = NEXT;
                    else
                        state_d = ADDR;
                end
            end
            NEXT:      state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs decode the state register directly, so a reset edge forces the line idle at once
    always_comb begin
        uart_tx = 1'b1;
        if (state_q == START_BIT)
            uart_tx = 1'b0;
        else if (state_q == DATA_BITS)
            uart_tx = tx_byte[bit_cnt];
        busy = (state_q != IDLE) && (state_q != DONE);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            reg_addr <= ADDR_FIRST;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == START_BIT || state_q == DATA_BITS || state_q == STOP_BIT)
                baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
            else
                baud_cnt <= '0;

            if (state_q == DATA_BITS && baud_end)
                bit_cnt <= bit_cnt + 3'd1;

            if (state_q == IDLE && start)
                reg_addr <= ADDR_FIRST;

            if (state_q == LATCH) begin
                shreg    <= regData;
                byte_idx <= BYTE_TOP;
            end

            // Address advances during the final stop bit so ADDR already presents the next register
            if (state_q == STOP_BIT && baud_end) begin
                if (byte_idx != 3'd0)
                    byte_idx <= byte_idx - 3'd1;
                else if (reg_addr != ADDR_LAST)
                    reg_addr <= reg_addr + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_sm_reg_dump.sv
// Directed bench for sm_reg_dump: three instances cover a single register, a full 0..31 sweep
// and a second single register; every UART cycle is compared against a timing model.
module tb_sm_reg_dump;

    localparam int BD_A = 4;
    localparam int FA   = 2;
    localparam int LA   = 2;
    localparam int BD_B = 2;
    localparam int FB   = 0;
    localparam int LB   = 31;
    localparam int BD_C = 3;
    localparam int FC   = 5;
    localparam int LC   = 5;
`ifdef SM_REG_DUMP_HEADER_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, start_c;
    logic [4:0]  addr_a, addr_b, addr_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        tx_a, tx_b, tx_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [31:0] a_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rd_a = (addr_a == 5'd2) ? a_val : 32'h0;
    assign rd_b = {4{3'b000, addr_b}};
    assign rd_c = (addr_c == 5'd5) ? 32'hDEADBEEF : 32'h0;

    sm_reg_dump #(.BAUD_DIV(BD_A), .REG_FIRST(FA), .REG_LAST(LA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .regAddr(addr_a), .regData(rd_a),
        .uart_tx(tx_a), .busy(busy_a), .done(done_a));

    sm_reg_dump #(.BAUD_DIV(BD_B), .REG_FIRST(FB), .REG_LAST(LB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .regAddr(addr_b), .regData(rd_b),
        .uart_tx(tx_b), .busy(busy_b), .done(done_b));

    sm_reg_dump #(.BAUD_DIV(BD_C), .REG_FIRST(FC), .REG_LAST(LC)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .regAddr(addr_c), .regData(rd_c),
        .uart_tx(tx_c), .busy(busy_c), .done(done_c));

    function automatic int bd_of(int w);
        case (w) 0: return BD_A; 1: return BD_B; default: return BD_C; endcase
    endfunction

    function automatic int first_of(int w);
        case (w) 0: return FA; 1: return FB; default: return FC; endcase
    endfunction

    function automatic int last_of(int w);
        case (w) 0: return LA; 1: return LB; default: return LC; endcase
    endfunction

    function automatic logic get_tx(int w);
        case (w) 0: return tx_a; 1: return tx_b; default: return tx_c; endcase
    endfunction

    function automatic logic get_busy(int w);
        case (w) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
    endfunction

    function automatic logic get_done(int w);
        case (w) 0: return done_a; 1: return done_b; default: return done_c; endcase
    endfunction

    function automatic logic [4:0] get_addr(int w);
        case (w) 0: return addr_a; 1: return addr_b; default: return addr_c; endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    // Hand-set register contents; header byte is {3'b101, addr}
    function automatic logic [7:0] exp_byte(int w, int r, int bi);
        logic [4:0]  a;
        logic [31:0] d;
        a = 5'(first_of(w) + r);
        case (w)
            0:       d = 32'h12345678;
            1:       d = {4{3'b000, a}};
            default: d = 32'hDEADBEEF;
        endcase
        if (NB == 5 && bi == 0) return {3'b101, a};
        return 8'(d >> ((NB - 1 - bi) * 8));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One dump on instance w. abort_j >= 0 resets after that sample; poke_j >= 0 pulses start
    // while busy (and again in the done cycle) and changes the CPU value after it was latched.
    task automatic run_dump(input int w, input int abort_j, input int poke_j);
        int bd, n, len, last_j, r, t, u, bi, p, bitn;
        int line_err, ctl_err, dones;
        logic [7:0] obs, expb;
        logic etx, ebusy, edone;
        bit aborted;
        bd = bd_of(w);
        n = last_of(w) - first_of(w) + 1;
        len = 2 + NB * 10 * bd;
        last_j = n * len + 1;
        line_err = 0; ctl_err = 0; dones = 0; obs = 8'h00; aborted = 1'b0;
        a_val = 32'h12345678;
        set_start(w, 1'b1);
        for (int j = 0; j <= last_j; j++) begin
            @(negedge clk);
            if (j == 0) set_start(w, 1'b0);
            etx = 1'b1; ebusy = 1'b1; edone = 1'b0;
            if (j == last_j) begin
                ebusy = 1'b0;
                edone = 1'b1;
                chk("done_at_end", {31'b0, get_done(w)}, 32'd1);
            end else if (j < n * len) begin
                r = j / len;
                t = j % len;
                if (t == 0 && get_addr(w) !== 5'(first_of(w) + r)) ctl_err++;
                if (t >= 2) begin
                    u = t - 2;
                    bi = u / (10 * bd);
                    p = u % (10 * bd);
                    bitn = p / bd;
                    expb = exp_byte(w, r, bi);
                    if (bitn == 0) etx = 1'b0;
                    else if (bitn <= 8) etx = expb[bitn-1];
                    if (bitn >= 1 && bitn <= 8 && (p % bd) == bd / 2) obs[bitn-1] = get_tx(w);
                    if (p == 10 * bd - 1) chk("byte", {24'b0, obs}, {24'b0, expb});
                end
            end
            if (get_tx(w) !== etx) line_err++;
            if (get_busy(w) !== ebusy || get_done(w) !== edone) ctl_err++;
            if (get_done(w) === 1'b1) dones++;
            if (poke_j >= 0 && j == poke_j) begin
                set_start(w, 1'b1);
                a_val = 32'hFFFF_FFFF;
            end
            if (poke_j >= 0 && j == poke_j + 1) set_start(w, 1'b0);
            if (poke_j >= 0 && j == last_j) set_start(w, 1'b1);
            if (j == abort_j) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_tx", {31'b0, get_tx(w)}, 32'd1);
                chk("abort_busy", {31'b0, get_busy(w)}, 32'd0);
                chk("abort_addr", {27'b0, get_addr(w)}, 32'(first_of(w)));
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        chk("line_wave", 32'(line_err), 32'd0);
        chk("busy_done_wave", 32'(ctl_err), 32'd0);
        if (!aborted) begin
            chk("done_count", 32'(dones), 32'd1);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                set_start(w, 1'b0);
                chk("post_idle", {24'b0, get_tx(w), get_busy(w), get_done(w), get_addr(w)},
                    {24'b0, 1'b1, 1'b0, 1'b0, 5'(last_of(w))});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        a_val = 32'h12345678;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            for (int w = 0; w < 3; w++)
                chk("reset_idle", {24'b0, get_tx(w), get_busy(w), get_done(w), get_addr(w)},
                    {24'b0, 1'b1, 1'b0, 1'b0, 5'(first_of(w))});
        end

        run_dump(0, -1, -1);
        run_dump(0, -1, 2 + 2 * 10 * BD_A + 5);
        run_dump(1, 2 + 10 * BD_B + 3 * BD_B, -1);
        run_dump(1, -1, -1);
        run_dump(2, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
